// File: rtl/ptw_pkg.sv
// Shared page-table-walker definitions: responder FSM encoding, address width,
// byte-enable constant and the physical-address legality rule.
package ptw_pkg;

   localparam int PTE_ADDR_W = 34;
   localparam logic [3:0] FULL_WORD_BE = 4'hF;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      ISSUE  = 3'd2,
      WAIT_R = 3'd3,
      RESP   = 3'd4,
      ERR    = 3'd5
   } ptw_state_e;

   // A PTE address is unusable if it lies above 4 GiB or is not word aligned.
   function automatic logic addr_err(input logic [PTE_ADDR_W-1:0] a);
      return (a[PTE_ADDR_W-1:32] != '0) || (a[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/ptw_mem_responder.sv
// Responder for PTW memory requests: latches a request pulse, range-checks it and
// replays it on the data-memory req/gnt/rvalid port, answering with a ready pulse.
module ptw_mem_responder
   import ptw_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int STAT_WIDTH     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ptw_req,
   input  logic [PTE_ADDR_W-1:0] ptw_addr,
   input  logic                  ptw_write,
   input  logic [31:0]           ptw_wdata,
   output logic [31:0]           ptw_rdata,
   output logic                  ptw_ready,
   output logic                  ptw_err,
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic [31:0]           mem_addr,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata,
   output logic                  overrun,
   output logic [STAT_WIDTH-1:0] stat_reqs,
   output logic [STAT_WIDTH-1:0] stat_errs
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   ptw_state_e state_q, state_d;

   logic [PTE_ADDR_W-1:0] addr_q;
   logic                  write_q;
   logic [31:0]           wdata_q;
   logic [TW-1:0]         timer_q, timer_d;

   logic [31:0] ptw_rdata_q, ptw_rdata_d;
   logic        ptw_ready_q, ptw_ready_d;
   logic        ptw_err_q, ptw_err_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        overrun_q, overrun_d;

   logic capture;
   logic timer_expired;

   assign capture       = (state_q == IDLE) && ptw_req;
   assign timer_expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A response in the last allowed WAIT_R cycle beats the timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ptw_req) state_d = CHECK;
         CHECK:   state_d = addr_err(addr_q) ? ERR : ISSUE;
         ISSUE:   if (mem_gnt) state_d = WAIT_R;
         WAIT_R: begin
            if (mem_rvalid) begin
               state_d = RESP;
            end else if (timer_expired) begin
               state_d = ERR;
            end
         end
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ptw_rdata_d = ptw_rdata_q;
      ptw_ready_d = 1'b0;
      ptw_err_d   = 1'b0;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      timer_d     = timer_q;
      overrun_d   = overrun_q | (ptw_req && (state_q != IDLE));
      unique case (state_q)
         IDLE: begin
            if (ptw_req) ptw_rdata_d = '0;
         end
         CHECK: begin
            if (!addr_err(addr_q)) begin
               mem_req_d   = 1'b1;
               mem_addr_d  = {addr_q[31:2], 2'b00};
               mem_we_d    = write_q;
               mem_be_d    = FULL_WORD_BE;
               mem_wdata_d = wdata_q;
            end
         end
         ISSUE: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               timer_d   = '0;
            end
         end
         WAIT_R: begin
            timer_d = timer_q + TW'(1);
            if (mem_rvalid && !write_q) ptw_rdata_d = mem_rdata;
         end
         RESP: begin
            ptw_ready_d = 1'b1;
         end
         ERR: begin
            ptw_ready_d = 1'b1;
            ptw_err_d   = 1'b1;
            ptw_rdata_d = '0;
         end
         default: begin
            ptw_ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptw_rdata_q <= '0;
         ptw_ready_q <= 1'b0;
         ptw_err_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         overrun_q   <= 1'b0;
         timer_q     <= '0;
      end else begin
         ptw_rdata_q <= ptw_rdata_d;
         ptw_ready_q <= ptw_ready_d;
         ptw_err_q   <= ptw_err_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         overrun_q   <= overrun_d;
         timer_q     <= timer_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else if (capture) begin
         addr_q  <= ptw_addr;
         write_q <= ptw_write;
         wdata_q <= ptw_wdata;
      end
   end

   sat_counter #(.WIDTH(STAT_WIDTH)) u_req_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (capture),
      .count_o (stat_reqs)
   );

   sat_counter #(.WIDTH(STAT_WIDTH)) u_err_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (state_q == ERR),
      .count_o (stat_errs)
   );

   assign ptw_rdata = ptw_rdata_q;
   assign ptw_ready = ptw_ready_q;
   assign ptw_err   = ptw_err_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Self-checking bench for ptw_mem_responder: directed vector table, hand-written
// overrun/reset sequences, then random transactions against a latency/status model.
module tb_ptw_mem_responder;

   localparam int T  = 8;
   localparam int SW = 4;
   localparam int SAT_MAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ptw_req;
   logic [33:0]   ptw_addr;
   logic          ptw_write;
   logic [31:0]   ptw_wdata;
   logic [31:0]   ptw_rdata;
   logic          ptw_ready;
   logic          ptw_err;
   logic          mem_req;
   logic          mem_gnt;
   logic [31:0]   mem_addr;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;
   logic          overrun;
   logic [SW-1:0] stat_reqs;
   logic [SW-1:0] stat_errs;

   int nChecks = 0;
   int nFails  = 0;
   int mReqs   = 0;
   int mErrs   = 0;

   always #5 clk = ~clk;

   ptw_mem_responder #(.TIMEOUT_CYCLES(T), .STAT_WIDTH(SW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ptw_req    (ptw_req),
      .ptw_addr   (ptw_addr),
      .ptw_write  (ptw_write),
      .ptw_wdata  (ptw_wdata),
      .ptw_rdata  (ptw_rdata),
      .ptw_ready  (ptw_ready),
      .ptw_err    (ptw_err),
      .mem_req    (mem_req),
      .mem_gnt    (mem_gnt),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .overrun    (overrun),
      .stat_reqs  (stat_reqs),
      .stat_errs  (stat_errs)
   );

   typedef struct {
      logic [33:0] addr;
      logic        wr;
      logic [31:0] wd;
      int          gd;
      int          rv;
      logic [31:0] rd;
      int          lat;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic badAddr(input logic [33:0] a);
      return (a[33:32] != 2'b00) || (a[1:0] != 2'b00);
   endfunction

   function automatic int satInc(input int v);
      return (v >= SAT_MAX) ? SAT_MAX : v + 1;
   endfunction

   task automatic checkAllZero(input string name);
      checkOutput({name, "_rdata"}, 64'(ptw_rdata), 64'd0);
      checkOutput({name, "_maddr"}, 64'(mem_addr), 64'd0);
      checkOutput({name, "_mwdata"}, 64'(mem_wdata), 64'd0);
      checkOutput({name, "_ctrl"},
                  64'({ptw_ready, ptw_err, mem_req, mem_we, mem_be, overrun, stat_reqs, stat_errs}),
                  64'd0);
   endtask

   // One PTW transaction with a reactive memory: grant on the (gd+1)th request cycle,
   // rvalid rv cycles after the grant cycle's successor; rv >= T means the timeout wins.
   task automatic applyStimulus(input string tag, input logic [33:0] addr, input logic wr,
                                input logic [31:0] wd, input int gd, input int rv,
                                input logic [31:0] rd, input int expLat, input logic expErr,
                                input logic [31:0] expRdata, input bit inject);
      int   cyc = 0;
      int   reqCycles = 0;
      int   grantCyc = -1;
      logic fieldsBad = 1'b0;
      logic seenReady = 1'b0;
      ptw_req   = 1'b1;
      ptw_addr  = addr;
      ptw_write = wr;
      ptw_wdata = wd;
      step();
      cyc = 1;
      ptw_req   = 1'b0;
      ptw_addr  = $urandom;
      ptw_wdata = $urandom;
      while (cyc < 300) begin
         if (ptw_ready) begin
            seenReady = 1'b1;
            break;
         end
         ptw_req    = 1'b0;
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (mem_req) begin
            reqCycles++;
            if (mem_addr !== {addr[31:2], 2'b00} || mem_we !== wr || mem_be !== 4'hF ||
                (wr && mem_wdata !== wd))
               fieldsBad = 1'b1;
            if (reqCycles == gd + 1) begin
               mem_gnt  = 1'b1;
               grantCyc = cyc;
            end
            if (inject && reqCycles == 1) begin
               ptw_req  = 1'b1;
               ptw_addr = 34'h0_0000_0ABC;
            end
         end
         if (grantCyc >= 0 && cyc == grantCyc + 1 + rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
         end
         step();
         cyc++;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      ptw_req    = 1'b0;
      checkOutput({tag, "_ready_seen"}, 64'(seenReady), 64'd1);
      checkOutput({tag, "_latency"}, 64'(cyc), 64'(expLat));
      checkOutput({tag, "_err"}, 64'(ptw_err), 64'(expErr));
      checkOutput({tag, "_rdata"}, 64'(ptw_rdata), 64'(expRdata));
      checkOutput({tag, "_mem_req_cycles"}, 64'(reqCycles), badAddr(addr) ? 64'd0 : 64'(gd + 1));
      checkOutput({tag, "_mem_fields"}, 64'(fieldsBad), 64'd0);
      mReqs = satInc(mReqs);
      if (expErr) mErrs = satInc(mErrs);
      checkOutput({tag, "_stat_reqs"}, 64'(stat_reqs), 64'(mReqs));
      checkOutput({tag, "_stat_errs"}, 64'(stat_errs), 64'(mErrs));
      step();
      checkOutput({tag, "_ready_pulse"}, 64'(ptw_ready), 64'd0);
      checkOutput({tag, "_rdata_hold"}, 64'(ptw_rdata), 64'(expRdata));
   endtask

   initial begin
      logic [33:0] ra;
      logic        rw, rErr, rBad;
      logic [31:0] rWd, rRd;
      int          rGd, rRv, rLat, strayReady;

      vecs[0] = '{34'h0_8000_1004, 1'b0, 32'h0,         0, 0,  32'h2000_0401, 5,  1'b0, 32'h2000_0401};
      vecs[1] = '{34'h0_8000_1008, 1'b1, 32'h2000_04C7, 3, 0,  32'hDEAD_BEEF, 8,  1'b0, 32'h0};
      vecs[2] = '{34'h1_0000_0000, 1'b0, 32'h0,         0, 0,  32'h1234_5678, 3,  1'b1, 32'h0};
      vecs[3] = '{34'h0_0000_0002, 1'b0, 32'h0,         0, 0,  32'h1234_5678, 3,  1'b1, 32'h0};
      vecs[4] = '{34'h0_0000_1000, 1'b0, 32'h0,         0, 99, 32'hCAFE_0001, 12, 1'b1, 32'h0};
      vecs[5] = '{34'h0_0000_2000, 1'b0, 32'h0,         0, 7,  32'hCAFE_0002, 12, 1'b0, 32'hCAFE_0002};
      vecs[6] = '{34'h0_4000_0010, 1'b0, 32'h0,         2, 3,  32'h0BAD_F00D, 10, 1'b0, 32'h0BAD_F00D};

      rst_n = 1'b0;
      ptw_req = 1'b0; ptw_addr = '0; ptw_write = 1'b0; ptw_wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #1;
      checkAllZero("reset");
      step(); step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 7; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].gd,
                       vecs[i].rv, vecs[i].rd, vecs[i].lat, vecs[i].err, vecs[i].rdata, 1'b0);
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hFFFF_FFFF;
         step();
         mem_rvalid = 1'b0;
         checkOutput($sformatf("vec%0d_stray_rvalid", i), 64'(ptw_ready), 64'd0);
      end
      checkOutput("no_overrun_yet", 64'(overrun), 64'd0);

      applyStimulus("overrun", 34'h0_0010_0020, 1'b0, 32'h0, 2, 1, 32'h5555_AAAA, 8, 1'b0,
                    32'h5555_AAAA, 1'b1);
      checkOutput("overrun_flag", 64'(overrun), 64'd1);
      strayReady = 0;
      for (int i = 0; i < 10; i++) begin
         if (ptw_ready || mem_req) strayReady++;
         step();
      end
      checkOutput("overrun_single_access", 64'(strayReady), 64'd0);
      checkOutput("overrun_sticky", 64'(overrun), 64'd1);

      ptw_req = 1'b1; ptw_addr = 34'h0_0000_3000; ptw_write = 1'b0;
      step();
      ptw_req = 1'b0;
      step();
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      checkAllZero("reset_mid");
      step();
      rst_n = 1'b1;
      mReqs = 0;
      mErrs = 0;
      strayReady = 0;
      for (int i = 0; i < 12; i++) begin
         mem_rvalid = (i == 2);
         if (ptw_ready) strayReady++;
         step();
      end
      mem_rvalid = 1'b0;
      checkOutput("reset_mid_no_ready", 64'(strayReady), 64'd0);
      applyStimulus("after_reset", 34'h0_0000_4004, 1'b0, 32'h0, 0, 0, 32'h7777_0001, 5, 1'b0,
                    32'h7777_0001, 1'b0);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0:       ra = {2'($urandom_range(1, 3)), 32'($urandom) & 32'hFFFF_FFFC};
            1:       ra = {2'b00, 30'($urandom), 2'($urandom_range(1, 3))};
            default: ra = {2'b00, 32'($urandom) & 32'hFFFF_FFFC};
         endcase
         rw   = 1'($urandom);
         rWd  = $urandom;
         rRd  = $urandom;
         rGd  = $urandom_range(0, 3);
         rRv  = $urandom_range(0, T + 1);
         rBad = badAddr(ra);
         rErr = rBad || (rRv >= T);
         if (rBad)          rLat = 3;
         else if (rRv >= T) rLat = 4 + rGd + T;
         else               rLat = 5 + rGd + rRv;
         applyStimulus($sformatf("rnd%0d", n), ra, rw, rWd, rGd, rRv, rRd, rLat, rErr,
                       (!rErr && !rw) ? rRd : 32'h0, 1'b0);
      end
      checkOutput("final_overrun_clear", 64'(overrun), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/ptw_mem_responder.md
Name: ptw_mem_responder

Overview:
- Responder end of the page-table-walker memory interface; PTW is the initiator.
- Latches each single-cycle PTW request (PTE read or A/D write-back), range-checks the 34-bit physical address, and replays it on the shared 32-bit data-memory port using a req/gnt/rvalid handshake.
- Returns a one-cycle ready with read data valid in that same cycle, so the PTW can sample it combinationally in its WAIT states.
- Sits between the PTW and the data-memory arbiter.

Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed from memory grant to rvalid before an error response; width is $clog2(TIMEOUT_CYCLES+1).
- STAT_WIDTH, 16: width of the saturating request and error counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ptw_req  in  1  single-cycle request pulse from the PTW
- ptw_addr  in  34  physical PTE address
- ptw_write  in  1  1 = A/D write-back, 0 = PTE read
- ptw_wdata  in  32  write data
- ptw_rdata  out  32  read data; valid while ptw_ready=1
- ptw_ready  out  1  single-cycle completion pulse
- ptw_err  out  1  qualifies ptw_ready: access error
- mem_req  out  1  memory request; held until granted
- mem_gnt  in  1  arbiter grant
- mem_addr  out  32  word address to memory, low two bits 0
- mem_we  out  1  write enable
- mem_be  out  4  byte enables, always 4'hF
- mem_wdata  out  32  write data
- mem_rvalid  in  1  response strobe; acks both reads and writes
- mem_rdata  in  32  read data
- overrun  out  1  sticky: ptw_req arrived while busy
- stat_reqs  out  STAT_WIDTH  accepted requests, saturating
- stat_errs  out  STAT_WIDTH  error responses, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including ptw_rdata, mem_addr, overrun and both counters.
  - Reset mid-transaction abandons it; no ptw_ready is issued.
- Capture: in IDLE, ptw_req=1 latches addr, write and wdata, and increments stat_reqs.
- Address check, applied to the latched request in CHECK. Error if either holds:
  - addr[33:32] != 0 (outside the 32-bit physical space)
  - addr[1:0] != 0 (misaligned PTE)
- States:
  - IDLE: ptw_req -> CHECK.
  - CHECK: address error -> ERR; otherwise drive mem_req=1, mem_addr, mem_we and mem_wdata -> ISSUE.
  - ISSUE: hold mem_req and all mem_* fields stable until mem_gnt=1. On the grant cycle, deassert mem_req the next cycle, clear the timer -> WAIT_R. No timeout applies in ISSUE; the arbiter guarantees eventual grant.
  - WAIT_R:
    - mem_rvalid=1: capture mem_rdata into ptw_rdata (reads only; writes keep 0) -> RESP.
    - Timer reaches TIMEOUT_CYCLES with no rvalid -> ERR.
    - rvalid arriving on the same cycle as expiry wins -> RESP.
  - RESP: ptw_ready=1, ptw_err=0 for one cycle -> IDLE.
  - ERR: ptw_ready=1, ptw_err=1, ptw_rdata=0 for one cycle; increment stat_errs -> IDLE.
- Latency, request pulse to ready:
  - Address error: 3 cycles.
  - Zero-wait grant and rvalid on the cycle after the grant: 5 cycles.
- ptw_rdata holds its value after ready until the next capture.
- ptw_req=1 in any state other than IDLE: request dropped, overrun set (sticky until reset), no other effect on the transaction in flight.
- A stray mem_rvalid outside WAIT_R is ignored.
- Counters saturate at all-ones and never wrap.

Decomposition:
- Shared package ptw_pkg:
  - State encoding constants IDLE=0, CHECK=1, ISSUE=2, WAIT_R=3, RESP=4, ERR=5.
  - PTE_ADDR_W=34.
  - FULL_WORD_BE=4'hF.
  - These are the same address-width constants the walker uses.
- One natural sub-module, sat_counter, instantiated twice for stat_reqs and stat_errs.

Test Plan:
- Read with zero-wait: ptw_req, addr=34'h0_8000_1004, mem_gnt tied 1, rvalid one cycle after grant with rdata=32'h2000_0401 -> mem_addr=32'h8000_1004, mem_we=0; ptw_ready 5 cycles after the req pulse with ptw_rdata=32'h2000_0401, ptw_err=0; stat_reqs=1.
- A/D write-back: ptw_write=1, wdata=32'h2000_04C7, grant delayed 3 cycles -> mem_req held 4 cycles with stable mem_addr/mem_we/mem_wdata and mem_be=4'hF; ptw_ready after rvalid; ptw_rdata=0.
- Address errors:
  - addr=34'h1_0000_0000 -> no mem_req ever, ptw_ready+ptw_err 3 cycles after req, stat_errs=1.
  - addr=34'h0_0000_0002 -> same response.
- Timeout: TIMEOUT_CYCLES=8, grant given, rvalid withheld -> ptw_err after 8 WAIT_R cycles; a later stray rvalid is ignored and the next request completes normally. Same-cycle rvalid and expiry -> RESP, ptw_err=0.
- Overrun: second ptw_req during ISSUE -> overrun=1, only one memory access and one ptw_ready.
- Reset mid-WAIT_R: rst_n low one cycle -> all outputs 0 immediately, no ready; next request serviced normally.
